// File: rtl/digit_feature_extract.sv
// Digit feature extractor: loads per-digit borders from the projection border RAMs, then
// counts stroke crossings on three probe lines per digit over the following frame.
module digit_feature_extract #(
  parameter int NUM_ROW = 1,
  parameter int NUM_COL = 4,
  parameter int DEPBIT  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_vsync,
  input  logic              frame_de,
  input  logic              monoc,
  input  logic [10:0]       xpos,
  input  logic [10:0]       ypos,
  input  logic              project_done_flag,
  input  logic [3:0]        num_col,
  input  logic [3:0]        num_row,
  output logic [DEPBIT-1:0] col_border_addr_rd,
  input  logic [DEPBIT-1:0] col_border_data_rd,
  output logic [DEPBIT-1:0] row_border_addr_rd,
  input  logic [DEPBIT-1:0] row_border_data_rd,
  output logic              feat_valid,
  output logic [3:0]        feat_idx,
  output logic [1:0]        feat_v,
  output logic [1:0]        feat_h1,
  output logic [1:0]        feat_h2,
  output logic              feat_done
);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, SCAN, OUT} state_t;

  state_t              state_q;
  logic                pd_q, vs_q;
  logic [3:0]          nc_q;
  logic                empty_q;
  logic [4:0]          ld_cnt_q;
  logic [3:0]          out_cnt_q;
  logic [DEPBIT-1:0]   col_addr_q, row_addr_q;
  logic                feat_valid_q, feat_done_q;
  logic [3:0]          feat_idx_q;
  logic [1:0]          feat_v_q, feat_h1_q, feat_h2_q;

  logic [10:0]         l_q  [NUM_COL];
  logic [10:0]         r_q  [NUM_COL];
  logic [10:0]         xm_q [NUM_COL];
  logic [10:0]         t_q, b_q, ya_q, yb_q;
  logic [NUM_COL-1:0]  ok_q, vp_q, hp1_q, hp2_q;
  logic [1:0]          cv_q  [NUM_COL];
  logic [1:0]          ch1_q [NUM_COL];
  logic [1:0]          ch2_q [NUM_COL];

  logic                rise_d, vfall_d, fg_d, empty_d;
  logic [3:0]          nc_d;
  logic [4:0]          two_nc_d, ld_nxt_d;
  logic [10:0]         col_ext_d, row_ext_d, h_d, ya_d, yb_d;
  logic [10:0]         xm_d [NUM_COL];
  logic [NUM_COL-1:0]  ok_d;

  always_comb begin
    rise_d    = project_done_flag & ~pd_q;
    vfall_d   = vs_q & ~frame_vsync;
    fg_d      = frame_de & ~monoc;
    nc_d      = (num_col > 4'(NUM_COL)) ? 4'(NUM_COL) : num_col;
    empty_d   = (nc_d == '0) || (num_row == '0) || (NUM_ROW == 0);
    two_nc_d  = {nc_q, 1'b0};
    ld_nxt_d  = ld_cnt_q + 5'd1;
    col_ext_d = 11'(col_border_data_rd);
    row_ext_d = 11'(row_border_data_rd);
    h_d       = b_q - t_q;
    ya_d      = t_q + (h_d >> 2) + (h_d >> 3);
    yb_d      = b_q - (h_d >> 2) - (h_d >> 3);
    ok_d      = '0;
    for (int unsigned k = 0; k < NUM_COL; k++) begin
      xm_d[k] = 11'(({1'b0, l_q[k]} + {1'b0, r_q[k]}) >> 1);
      ok_d[k] = (b_q >= t_q) && (r_q[k] >= l_q[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pd_q         <= 1'b0;
      vs_q         <= 1'b0;
      nc_q         <= '0;
      empty_q      <= 1'b0;
      ld_cnt_q     <= '0;
      out_cnt_q    <= '0;
      col_addr_q   <= '0;
      row_addr_q   <= '0;
      feat_valid_q <= 1'b0;
      feat_done_q  <= 1'b0;
      feat_idx_q   <= '0;
      feat_v_q     <= '0;
      feat_h1_q    <= '0;
      feat_h2_q    <= '0;
      t_q          <= '0;
      b_q          <= '0;
      ya_q         <= '0;
      yb_q         <= '0;
      ok_q         <= '0;
      vp_q         <= '0;
      hp1_q        <= '0;
      hp2_q        <= '0;
      for (int unsigned k = 0; k < NUM_COL; k++) begin
        l_q[k]   <= '0;
        r_q[k]   <= '0;
        xm_q[k]  <= '0;
        cv_q[k]  <= '0;
        ch1_q[k] <= '0;
        ch2_q[k] <= '0;
      end
    end else begin
      pd_q         <= project_done_flag;
      vs_q         <= frame_vsync;
      feat_valid_q <= 1'b0;
      feat_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise_d) begin
            state_q    <= LOAD;
            nc_q       <= nc_d;
            empty_q    <= empty_d;
            ld_cnt_q   <= '0;
            col_addr_q <= empty_d ? '0 : DEPBIT'(1);
          end
        end
        LOAD: begin
          if (empty_q) begin
            feat_done_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            // Address issued in cycle c returns data in cycle c+1: columns fill cycles
            // 1..2nc, top at 2nc+1, bottom at 2nc+2.
            ld_cnt_q   <= ld_nxt_d;
            col_addr_q <= (ld_nxt_d < two_nc_d) ? DEPBIT'(ld_cnt_q + 5'd2) : '0;
            row_addr_q <= (ld_nxt_d == two_nc_d)          ? DEPBIT'(1) :
                          (ld_nxt_d == two_nc_d + 5'd1)   ? DEPBIT'(2) : '0;
            for (int unsigned k = 0; k < NUM_COL; k++) begin
              if (ld_cnt_q <= two_nc_d && ld_cnt_q == 5'(2*k + 1)) l_q[k] <= col_ext_d;
              if (ld_cnt_q <= two_nc_d && ld_cnt_q == 5'(2*k + 2)) r_q[k] <= col_ext_d;
            end
            if (ld_cnt_q == two_nc_d + 5'd1) t_q <= row_ext_d;
            if (ld_cnt_q == two_nc_d + 5'd2) begin
              b_q     <= row_ext_d;
              state_q <= ARM;
            end
          end
        end
        ARM: begin
          ya_q  <= ya_d;
          yb_q  <= yb_d;
          ok_q  <= ok_d;
          vp_q  <= '0;
          hp1_q <= '0;
          hp2_q <= '0;
          for (int unsigned k = 0; k < NUM_COL; k++) begin
            xm_q[k]  <= xm_d[k];
            cv_q[k]  <= '0;
            ch1_q[k] <= '0;
            ch2_q[k] <= '0;
          end
          if (vfall_d) state_q <= SCAN;
        end
        SCAN: begin
          if (frame_de) begin
            for (int unsigned k = 0; k < NUM_COL; k++) begin
              if (xpos == xm_q[k]) begin
                if (ypos == t_q - 11'd1) begin
                  vp_q[k] <= 1'b0;
                end else if (ypos >= t_q && ypos <= b_q) begin
                  if (fg_d && !vp_q[k] && cv_q[k] != 2'd3) cv_q[k] <= cv_q[k] + 2'd1;
                  vp_q[k] <= fg_d;
                end
              end
              // The left border acts as background so a stroke touching it still counts.
              if (ypos == ya_q && xpos >= l_q[k] && xpos <= r_q[k]) begin
                if (fg_d && (xpos == l_q[k] || !hp1_q[k]) && ch1_q[k] != 2'd3)
                  ch1_q[k] <= ch1_q[k] + 2'd1;
                hp1_q[k] <= fg_d;
              end
              if (ypos == yb_q && xpos >= l_q[k] && xpos <= r_q[k]) begin
                if (fg_d && (xpos == l_q[k] || !hp2_q[k]) && ch2_q[k] != 2'd3)
                  ch2_q[k] <= ch2_q[k] + 2'd1;
                hp2_q[k] <= fg_d;
              end
            end
          end
          if (vfall_d) begin
            state_q   <= OUT;
            out_cnt_q <= '0;
          end
        end
        OUT: begin
          if (out_cnt_q < nc_q) begin
            feat_valid_q <= 1'b1;
            feat_idx_q   <= out_cnt_q;
            out_cnt_q    <= out_cnt_q + 4'd1;
            for (int unsigned k = 0; k < NUM_COL; k++) begin
              if (out_cnt_q == 4'(k)) begin
                feat_v_q  <= ok_q[k] ? cv_q[k]  : 2'd0;
                feat_h1_q <= ok_q[k] ? ch1_q[k] : 2'd0;
                feat_h2_q <= ok_q[k] ? ch2_q[k] : 2'd0;
              end
            end
          end else begin
            feat_done_q <= 1'b1;
            feat_idx_q  <= '0;
            feat_v_q    <= '0;
            feat_h1_q   <= '0;
            feat_h2_q   <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign col_border_addr_rd = col_addr_q;
  assign row_border_addr_rd = row_addr_q;
  assign feat_valid         = feat_valid_q;
  assign feat_idx           = feat_idx_q;
  assign feat_v             = feat_v_q;
  assign feat_h1            = feat_h1_q;
  assign feat_h2            = feat_h2_q;
  assign feat_done          = feat_done_q;

endmodule

// File: tb/tb_digit_feature_extract.sv
// Bench for digit_feature_extract: border RAMs plus synthetic frames; each feature record
// is compared with crossings counted directly on the frame image.
module tb_digit_feature_extract;
  localparam int W = 100;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_vsync, frame_de, monoc;
  logic [10:0] xpos, ypos;
  logic        project_done_flag;
  logic [3:0]  num_col, num_row;
  logic [9:0]  col_addr, col_data, row_addr, row_data;
  logic        feat_valid, feat_done;
  logic [3:0]  feat_idx;
  logic [1:0]  feat_v, feat_h1, feat_h2;

  always #5 clk = ~clk;

  digit_feature_extract #(.NUM_ROW(1), .NUM_COL(4), .DEPBIT(10)) dut (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .frame_de(frame_de),
    .monoc(monoc), .xpos(xpos), .ypos(ypos), .project_done_flag(project_done_flag),
    .num_col(num_col), .num_row(num_row),
    .col_border_addr_rd(col_addr), .col_border_data_rd(col_data),
    .row_border_addr_rd(row_addr), .row_border_data_rd(row_data),
    .feat_valid(feat_valid), .feat_idx(feat_idx), .feat_v(feat_v),
    .feat_h1(feat_h1), .feat_h2(feat_h2), .feat_done(feat_done)
  );

  logic [9:0] col_mem [0:1023];
  logic [9:0] row_mem [0:1023];
  always @(posedge clk) begin
    col_data <= col_mem[col_addr];
    row_data <= row_mem[row_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // record monitor
  int cyc = 0;
  int q_idx[$], q_v[$], q_h1[$], q_h2[$], q_cyc[$];
  int done_cnt = 0, done_cyc = 0;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (feat_valid) begin
      q_idx.push_back(int'(feat_idx)); q_v.push_back(int'(feat_v));
      q_h1.push_back(int'(feat_h1));   q_h2.push_back(int'(feat_h2));
      q_cyc.push_back(cyc);
    end
    if (feat_done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic clear_mon();
    q_idx.delete(); q_v.delete(); q_h1.delete(); q_h2.delete(); q_cyc.delete();
    done_cnt = 0;
  endtask

  // reference scene and model
  bit img [H][W];
  int Lb[4], Rb[4], Tb, Bb;

  function automatic int sat3(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  function automatic int exp_v(input int k);
    int xm, c; bit p;
    if (Bb < Tb || Rb[k] < Lb[k]) return 0;
    xm = (Lb[k] + Rb[k]) / 2; c = 0; p = 0;
    for (int y = Tb; y <= Bb; y++) begin
      if (img[y][xm] && !p) c++;
      p = img[y][xm];
    end
    return sat3(c);
  endfunction

  function automatic int exp_h(input int k, input bit lower);
    int h, y, c; bit p;
    if (Bb < Tb || Rb[k] < Lb[k]) return 0;
    h = Bb - Tb;
    y = lower ? (Bb - h/4 - h/8) : (Tb + h/4 + h/8);
    c = 0; p = 0;
    for (int x = Lb[k]; x <= Rb[k]; x++) begin
      if (img[y][x] && !p) c++;
      p = img[y][x];
    end
    return sat3(c);
  endfunction

  task automatic clear_img();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 1'b0;
  endtask

  task automatic fill(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) for (int x = x0; x <= x1; x++) img[y][x] = 1'b1;
  endtask

  task automatic ring(input int k, input int sw);
    fill(Lb[k], Lb[k]+sw-1, Tb, Bb); fill(Rb[k]-sw+1, Rb[k], Tb, Bb);
    fill(Lb[k], Rb[k], Tb, Tb+sw-1); fill(Lb[k], Rb[k], Bb-sw+1, Bb);
  endtask

  task automatic noise(input int x0, input int x1, input int y0, input int y1, input int pct);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        if ($urandom_range(0, 99) < pct) img[y][x] = 1'b1;
  endtask

  task automatic load_mem();
    for (int k = 0; k < 4; k++) begin
      col_mem[2*k+1] = 10'(Lb[k]);
      col_mem[2*k+2] = 10'(Rb[k]);
    end
    for (int a = 9; a < 16; a++) col_mem[a] = 10'd500;
    row_mem[1] = 10'(Tb);
    row_mem[2] = 10'(Bb);
  endtask

  // stimulus
  task automatic vsync_pulse();
    @(posedge clk); #1 frame_vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame_vsync = 1'b0;
  endtask

  task automatic drive_rows(input int nrows);
    for (int y = 0; y < nrows; y++) begin
      for (int x = 0; x < W; x++) begin
        @(posedge clk); #1;
        frame_de = 1'b1; xpos = 11'(x); ypos = 11'(y); monoc = !img[y][x];
      end
      @(posedge clk); #1 frame_de = 1'b0; monoc = 1'b1;
    end
  endtask

  task automatic check_run(input string name, input int n_exp);
    int waited, n;
    waited = 0;
    while (done_cnt == 0 && waited < 200) begin @(posedge clk); waited++; end
    repeat (5) @(posedge clk);
    check({name, "_done"}, done_cnt, 1);
    check({name, "_nrec"}, q_idx.size(), n_exp);
    n = (q_idx.size() < n_exp) ? q_idx.size() : n_exp;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_idx%0d", name, i), q_idx[i], i);
      check($sformatf("%s_v%0d",   name, i), q_v[i],  exp_v(i));
      check($sformatf("%s_h1_%0d", name, i), q_h1[i], exp_h(i, 1'b0));
      check($sformatf("%s_h2_%0d", name, i), q_h2[i], exp_h(i, 1'b1));
      check($sformatf("%s_cyc%0d", name, i), q_cyc[i] - q_cyc[0], i);
    end
    if (n > 0) check({name, "_done_lat"}, done_cyc - q_cyc[n-1], 1);
  endtask

  task automatic run_full(input string name, input int ncol, input int nrow,
                          input int n_exp, input bit hold);
    clear_mon();
    load_mem();
    num_col = 4'(ncol); num_row = 4'(nrow);
    @(posedge clk); #1 project_done_flag = 1'b1;
    repeat (20) @(posedge clk);
    vsync_pulse();
    drive_rows(H);
    vsync_pulse();
    check_run(name, n_exp);
    if (!hold) begin @(posedge clk); #1 project_done_flag = 1'b0; end
    repeat (3) @(posedge clk);
  endtask

  task automatic run_empty(input string name, input int ncol, input int nrow);
    int c0, waited;
    clear_mon();
    num_col = 4'(ncol); num_row = 4'(nrow);
    @(posedge clk); #1 project_done_flag = 1'b1; c0 = cyc;
    waited = 0;
    while (done_cnt == 0 && waited < 20) begin @(posedge clk); waited++; end
    repeat (5) @(posedge clk);
    check({name, "_done"}, done_cnt, 1);
    check({name, "_lat"}, done_cyc - c0, 2);
    check({name, "_nrec"}, q_idx.size(), 0);
    #1 project_done_flag = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic check_outs_zero(input string name);
    check({name, "_valid"}, int'(feat_valid), 0);
    check({name, "_done"},  int'(feat_done), 0);
    check({name, "_idx"},   int'(feat_idx), 0);
    check({name, "_cnts"},  int'({feat_v, feat_h1, feat_h2}), 0);
    check({name, "_caddr"}, int'(col_addr), 0);
    check({name, "_raddr"}, int'(row_addr), 0);
  endtask

  initial begin
    rst_n = 1'b0; frame_vsync = 1'b0; frame_de = 1'b0; monoc = 1'b1;
    xpos = '0; ypos = '0; project_done_flag = 1'b0; num_col = '0; num_row = '0;
    for (int a = 0; a < 1024; a++) begin col_mem[a] = '0; row_mem[a] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // "0" ring
    clear_img();
    Lb = '{10, 0, 0, 0}; Rb = '{30, 0, 0, 0}; Tb = 20; Bb = 60;
    ring(0, 3);
    run_full("t1", 1, 1, 1, 1'b0);
    if (q_v.size() > 0) begin
      check("t1_v_const", q_v[0], 2); check("t1_h1_const", q_h1[0], 2);
      check("t1_h2_const", q_h2[0], 2);
    end

    // "1" bar
    clear_img();
    fill(18, 22, 20, 60);
    run_full("t2", 1, 1, 1, 1'b0);
    if (q_v.size() > 0) begin
      check("t2_v_const", q_v[0], 1); check("t2_h1_const", q_h1[0], 1);
      check("t2_h2_const", q_h2[0], 1);
    end

    // four distinct digits
    clear_img();
    Lb = '{2, 27, 52, 77}; Rb = '{22, 47, 72, 97}; Tb = 5; Bb = 58;
    ring(0, 2);
    fill(35, 39, Tb, Bb);
    fill(52, 72, 10, 13); fill(52, 72, 30, 33); fill(52, 72, 50, 53);
    fill(80, 82, Tb, Bb); fill(92, 94, Tb, Bb); fill(77, 97, 5, 7);
    run_full("t3", 4, 1, 4, 1'b0);

    // randomized scenes; run 1 has one reversed column, run 2 has bottom above top
    for (int r = 0; r < 3; r++) begin
      int nc;
      clear_img();
      nc = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) begin
        Lb[k] = 25*k + $urandom_range(0, 4);
        Rb[k] = Lb[k] + $urandom_range(3, 19);
      end
      Tb = $urandom_range(0, 15);
      Bb = Tb + $urandom_range(6, 47);
      if (r == 1) begin nc = 4; Rb[1] = Lb[1] - 2; end
      if (r == 2) begin Tb = $urandom_range(20, 40); Bb = Tb - $urandom_range(1, 10); end
      noise(0, W-1, 0, H-1, 3);
      for (int k = 0; k < 4; k++)
        if (Rb[k] >= Lb[k] && Bb >= Tb) noise(Lb[k], Rb[k], Tb, Bb, $urandom_range(5, 45));
      if (r == 2) noise(0, W-1, 0, H-1, 20);
      run_full($sformatf("rnd%0d", r), nc, 1, nc, 1'b0);
    end

    // no digits / no rows
    run_empty("t4_nc0", 0, 1);
    run_empty("t4_nr0", 3, 0);

    // clamp to NUM_COL; flag held high across further frames
    clear_img();
    Lb = '{2, 27, 52, 77}; Rb = '{22, 47, 72, 97}; Tb = 5; Bb = 58;
    noise(0, W-1, Tb, Bb, 15);
    run_full("t5", 6, 1, 4, 1'b1);
    clear_mon();
    repeat (3) begin vsync_pulse(); repeat (10) @(posedge clk); end
    repeat (20) @(posedge clk);
    check("t5_hold_nrec", q_idx.size(), 0);
    check("t5_hold_done", done_cnt, 0);
    #1 project_done_flag = 1'b0;
    repeat (3) @(posedge clk);

    // reset mid-scan, then a fresh run
    clear_img();
    Lb = '{5, 40, 0, 0}; Rb = '{30, 70, 0, 0}; Tb = 8; Bb = 55;
    ring(0, 3); fill(53, 57, Tb, Bb);
    clear_mon(); load_mem();
    num_col = 4'd2; num_row = 4'd1;
    @(posedge clk); #1 project_done_flag = 1'b1;
    repeat (20) @(posedge clk);
    vsync_pulse();
    drive_rows(30);
    #1 rst_n = 1'b0; project_done_flag = 1'b0; frame_de = 1'b0;
    @(posedge clk); @(negedge clk);
    check_outs_zero("t6_rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("t6_nrec_after_rst", q_idx.size(), 0);
    check("t6_done_after_rst", done_cnt, 0);
    run_full("t6", 2, 1, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
